// File: rtl/game_pkg.sv
// Shared types for the two-player match scoreboard.
// Holds the FSM state enum, the BCD digit type and the largest BCD digit.
package game_pkg;

  typedef enum logic [1:0] {
    PLAY,
    HOLD,
    DONE
  } state_e;

  typedef logic [3:0] bcd_t;

  localparam int MAX_BCD = 9;

endpackage

// File: rtl/score_counter.sv
// Per-player saturating BCD win counter, one digit wide.
// Ports: clk, reset (sync, high), clr, inc -> count, at_limit (count == WIN_LIMIT).
module score_counter
  import game_pkg::*;
#(
  parameter int WIN_LIMIT = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] count,
  output logic       at_limit
);

  // Clamp so a bad limit can never push the digit past 9.
  localparam bcd_t LIM =
    (WIN_LIMIT > MAX_BCD) ? bcd_t'(MAX_BCD) : bcd_t'(WIN_LIMIT);

  bcd_t count_q;
  bcd_t count_d;

  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (inc && (count_q != LIM))
      count_d = count_q + bcd_t'(1);
  end

  always_ff @(posedge clk) begin
    if (reset)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign count    = count_q;
  assign at_limit = (count_q == LIM);

endmodule

// File: rtl/match_scoreboard.sv
// Two-player tug-of-war match scoreboard with round-win pulse and match end.
// Ports: clk, reset, new_match, l_end, r_end, l_press, r_press ->
//        score_l, score_r, gamereset, match_over, winner_r.
module match_scoreboard
  import game_pkg::*;
#(
  parameter int WIN_LIMIT     = 7,
  parameter bit REARM_RELEASE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       new_match,
  input  logic       l_end,
  input  logic       r_end,
  input  logic       l_press,
  input  logic       r_press,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       gamereset,
  output logic       match_over,
  output logic       winner_r
);

  state_e state_q;
  logic   gr_q;
  logic   over_q;
  logic   wr_q;
  logic   nm_q;

  bcd_t cnt_l;
  bcd_t cnt_r;
  logic lim_l;
  logic lim_r;

  logic win_l;
  logic win_r;
  logic inc_l;
  logic inc_r;
  logic last_l;
  logic last_r;

  // A simultaneous press by both players can never qualify either side.
  assign win_l = l_end & l_press & ~r_press;
  assign win_r = r_end & r_press & ~l_press;

  // Counters only advance from PLAY; the limit check is a backstop.
  assign inc_l = (state_q == PLAY) & ~new_match
               & win_l & ~(lim_l | lim_r);
  assign inc_r = (state_q == PLAY) & ~new_match
               & win_r & ~(lim_l | lim_r);

  // This round's win is the one that reaches the limit.
  assign last_l = (cnt_l == bcd_t'(WIN_LIMIT - 1));
  assign last_r = (cnt_r == bcd_t'(WIN_LIMIT - 1));

  score_counter #(
    .WIN_LIMIT(WIN_LIMIT)
  ) u_cnt_l (
    .clk     (clk),
    .reset   (reset),
    .clr     (new_match),
    .inc     (inc_l),
    .count   (cnt_l),
    .at_limit(lim_l)
  );

  score_counter #(
    .WIN_LIMIT(WIN_LIMIT)
  ) u_cnt_r (
    .clk     (clk),
    .reset   (reset),
    .clr     (new_match),
    .inc     (inc_r),
    .count   (cnt_r),
    .at_limit(lim_r)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PLAY;
      gr_q    <= 1'b0;
      over_q  <= 1'b0;
      wr_q    <= 1'b0;
      nm_q    <= 1'b0;
    end else begin
      nm_q <= new_match;
      gr_q <= 1'b0;
      if (new_match) begin
        state_q <= PLAY;
        over_q  <= 1'b0;
        wr_q    <= 1'b0;
        // Pulse only on the first cycle of a held request.
        gr_q    <= ~nm_q;
      end else begin
        unique case (state_q)
          PLAY: begin
            if (inc_l | inc_r) begin
              gr_q <= 1'b1;
              if ((inc_l & last_l) | (inc_r & last_r)) begin
                state_q <= DONE;
                over_q  <= 1'b1;
                wr_q    <= inc_r;
              end else begin
                state_q <= HOLD;
              end
            end
          end
          HOLD: begin
            if (!REARM_RELEASE || (!l_press && !r_press))
              state_q <= PLAY;
          end
          DONE: begin
            state_q <= DONE;
          end
          default: state_q <= PLAY;
        endcase
      end
    end
  end

  assign score_l    = cnt_l;
  assign score_r    = cnt_r;
  assign gamereset  = gr_q;
  assign match_over = over_q;
  assign winner_r   = wr_q;

endmodule

// File: tb/tb_match_scoreboard.sv
// Scoreboard bench for match_scoreboard: directed rounds plus random play.
// Expected outputs come from a plain integer match model queued per cycle.
module tb_match_scoreboard;

  localparam int WL = 3;
  localparam bit RR = 1'b1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       new_match = 1'b0;
  logic       l_end = 1'b0;
  logic       r_end = 1'b0;
  logic       l_press = 1'b0;
  logic       r_press = 1'b0;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic       gamereset;
  logic       match_over;
  logic       winner_r;

  int total = 0;
  int bad = 0;

  // {score_l, score_r, gamereset, match_over, winner_r}
  logic [10:0] expq[$];

  // Reference match model
  int m_sl = 0;
  int m_sr = 0;
  bit m_over = 0;
  bit m_wr = 0;
  bit m_wait = 0;
  bit m_pnm = 0;

  always #5 clk = ~clk;

  match_scoreboard #(
    .WIN_LIMIT    (WL),
    .REARM_RELEASE(RR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .new_match (new_match),
    .l_end     (l_end),
    .r_end     (r_end),
    .l_press   (l_press),
    .r_press   (r_press),
    .score_l   (score_l),
    .score_r   (score_r),
    .gamereset (gamereset),
    .match_over(match_over),
    .winner_r  (winner_r)
  );

  task automatic cyc(input bit rst, input bit nm,
                     input bit le, input bit re,
                     input bit lp, input bit rp);
    bit gr;
    bit lw;
    bit rw;
    @(negedge clk);
    reset = rst;
    new_match = nm;
    l_end = le;
    r_end = re;
    l_press = lp;
    r_press = rp;
    gr = 0;
    if (rst) begin
      m_sl = 0; m_sr = 0; m_over = 0;
      m_wr = 0; m_wait = 0; m_pnm = 0;
    end else begin
      lw = le && lp && !rp;
      rw = re && rp && !lp;
      if (nm) begin
        m_sl = 0; m_sr = 0; m_over = 0;
        m_wr = 0; m_wait = 0;
        gr = !m_pnm;
      end else if (m_over) begin
        gr = 0;
      end else if (m_wait) begin
        if (!RR || (!lp && !rp)) m_wait = 0;
      end else if (lw || rw) begin
        if (lw) m_sl++;
        else m_sr++;
        gr = 1;
        if (m_sl == WL || m_sr == WL) begin
          m_over = 1;
          m_wr = rw;
        end else begin
          m_wait = 1;
        end
      end
      m_pnm = nm;
    end
    expq.push_back({4'(m_sl), 4'(m_sr), gr, m_over, m_wr});
  endtask

  // Monitor: every cycle the DUT presents a fresh output word.
  always @(posedge clk) begin
    logic [10:0] e;
    logic [10:0] a;
    #1;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      a = {score_l, score_r, gamereset, match_over, winner_r};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL outputs t=%0t got sl=%0d sr=%0d gr=%0b mo=%0b wr=%0b want sl=%0d sr=%0d gr=%0b mo=%0b wr=%0b",
                 $time, a[10:7], a[6:3], a[2], a[1], a[0],
                 e[10:7], e[6:3], e[2], e[1], e[0]);
      end
    end
  end

  initial begin
    // 1: reset, then a left win
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 1, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    // 2: tie with both ends lit
    cyc(0, 0, 1, 1, 1, 1);
    cyc(0, 0, 0, 0, 0, 0);
    // 3: right win with r_press held 5 cycles
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0, 1);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    // 4: two more right wins reach the limit, then extra press
    for (int k = 0; k < 2; k++) begin
      cyc(0, 0, 0, 1, 0, 1);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
    end
    cyc(0, 0, 0, 1, 0, 1);
    cyc(0, 0, 1, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    // 5: new_match held 4 cycles in DONE
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    // 6: reset during the gamereset pulse cycle
    cyc(0, 0, 1, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    // left reaches the limit
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 1, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 0);
    end
    cyc(0, 0, 0, 0, 0, 0);
    // random play
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 299) == 0),
          ($urandom_range(0, 39) == 0),
          1'($urandom), 1'($urandom),
          ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 2) == 0));
    end
    cyc(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d left want 0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
